// File: rtl/muldiv_seq_if.sv
// Handshake and result bundle for the muldiv_seq sequential multiply/divide unit.
// The requester drives through master; the sequencer receives through slave.
interface muldiv_seq_if #(
    parameter int N = 4
);
    logic           START;
    logic           OP;
    logic [N-1:0]   A;
    logic [N-1:0]   B;
    logic           BUSY;
    logic           DONE;
    logic [2*N-1:0] Y;
    logic           DBZ;

    modport master (
        output START,
        output OP,
        output A,
        output B,
        input  BUSY,
        input  DONE,
        input  Y,
        input  DBZ
    );

    modport slave (
        input  START,
        input  OP,
        input  A,
        input  B,
        output BUSY,
        output DONE,
        output Y,
        output DBZ
    );
endinterface

// File: rtl/muldiv_seq.sv
// Multi-cycle unsigned shift-add multiplier / restoring divider, one step per clock.
// Define MULDIV_DIV_EN to build the divide datapath; otherwise every operation multiplies.
module muldiv_seq #(
    parameter int N = 4
) (
    input  logic          CLK,
    input  logic          N_RESET,
    muldiv_seq_if.slave   bus
);

    localparam int CW = $clog2(N + 1);
    localparam logic [CW-1:0] COUNT_INIT = CW'(N);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t          state;
    logic [CW-1:0]   count;
    logic            busy_q;
    logic            done_q;
    logic [2*N-1:0]  y_q;
    logic            dbz_q;

    logic [2*N-1:0]  acc;
    logic [2*N-1:0]  mcand;
    logic [N-1:0]    mplier;
    logic [2*N-1:0]  acc_next;

`ifdef MULDIV_DIV_EN
    logic            op_div;
    logic [N-1:0]    divisor;
    logic [N:0]      rem;
    logic [N-1:0]    quo;
    logic [N:0]      rem_shifted;
    logic [N+1:0]    trial;
    logic            q_bit;
    logic [N:0]      rem_next;
    logic [N-1:0]    quo_next;
`endif

    // One multiply step: conditionally add the shifted multiplicand.
    always_comb begin
        acc_next = acc;
        if (mplier[0]) begin
            acc_next = acc + mcand;
        end
    end

`ifdef MULDIV_DIV_EN
    // One restoring-divide step: the dividend shifts out of quo's MSB into the
    // partial remainder while quotient bits shift in at quo's LSB.
    always_comb begin
        rem_shifted = (rem << 1) | {{N{1'b0}}, quo[N-1]};
        trial       = {1'b0, rem_shifted} - {2'b00, divisor};
        q_bit       = ~trial[N+1];
        rem_next    = rem_shifted;
        if (q_bit) begin
            rem_next = trial[N:0];
        end
        quo_next    = {quo[N-2:0], q_bit};
    end
`endif

    always_ff @(posedge CLK or negedge N_RESET) begin
        if (!N_RESET) begin
            state   <= S_IDLE;
            count   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            y_q     <= '0;
            dbz_q   <= 1'b0;
            acc     <= '0;
            mcand   <= '0;
            mplier  <= '0;
`ifdef MULDIV_DIV_EN
            op_div  <= 1'b0;
            divisor <= '0;
            rem     <= '0;
            quo     <= '0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    if (bus.START) begin
                        state   <= S_RUN;
                        count   <= COUNT_INIT;
                        busy_q  <= 1'b1;
                        acc     <= '0;
                        mcand   <= {{N{1'b0}}, bus.A};
                        mplier  <= bus.B;
`ifdef MULDIV_DIV_EN
                        op_div  <= bus.OP;
                        divisor <= bus.B;
                        rem     <= '0;
                        quo     <= bus.A;
`endif
                    end
                end

                // The extra RUN cycle at count==0 registers the finished result.
                S_RUN: begin
                    if (count == '0) begin
                        state  <= S_DONE;
                        done_q <= 1'b1;
`ifdef MULDIV_DIV_EN
                        if (op_div) begin
                            y_q   <= {rem[N-1:0], quo};
                            dbz_q <= (divisor == '0);
                        end else begin
                            y_q   <= acc;
                            dbz_q <= 1'b0;
                        end
`else
                        y_q    <= acc;
                        dbz_q  <= 1'b0;
`endif
                    end else begin
                        count  <= count - 1'b1;
                        acc    <= acc_next;
                        mcand  <= mcand << 1;
                        mplier <= mplier >> 1;
`ifdef MULDIV_DIV_EN
                        rem    <= rem_next;
                        quo    <= quo_next;
`endif
                    end
                end

                S_DONE: begin
                    state  <= S_IDLE;
                    done_q <= 1'b0;
                    busy_q <= 1'b0;
                end

                default: begin
                    state  <= S_IDLE;
                    done_q <= 1'b0;
                    busy_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.BUSY = busy_q;
    assign bus.DONE = done_q;
    assign bus.Y    = y_q;
    assign bus.DBZ  = dbz_q;

endmodule

// File: tb/tb_muldiv_seq.sv
// Directed scoreboard bench for muldiv_seq; the reference model follows MULDIV_DIV_EN
// so the same bench covers both the divide-enabled and multiply-only builds.
module tb_muldiv_seq;

    localparam int N = 4;
`ifdef MULDIV_DIV_EN
    localparam bit DIV_EN = 1'b1;
`else
    localparam bit DIV_EN = 1'b0;
`endif

    logic CLK;
    logic N_RESET;

    muldiv_seq_if #(.N(N)) bus ();

    muldiv_seq #(.N(N)) dut (
        .CLK     (CLK),
        .N_RESET (N_RESET),
        .bus     (bus)
    );

    int errors = 0;
    int checks = 0;
    int doneCount = 0;
    int pushCount = 0;
    logic [2*N:0] sbq[$];

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // Independent reference: packed {Y, DBZ}.
    function automatic logic [2*N:0] model(input logic op, input logic [N-1:0] a,
                                           input logic [N-1:0] b);
        logic [2*N-1:0] y;
        logic           dbz;
        if (op && DIV_EN) begin
            if (b == '0) begin
                y   = {a, {N{1'b1}}};
                dbz = 1'b1;
            end else begin
                y   = {a % b, a / b};
                dbz = 1'b0;
            end
        end else begin
            y   = (2*N)'(a) * (2*N)'(b);
            dbz = 1'b0;
        end
        return {y, dbz};
    endfunction

    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
            $error("[TB] check %s did not match", tag);
        end
    endtask

    task automatic applyStimulus(input logic op, input logic [N-1:0] a,
                                 input logic [N-1:0] b, input bit push);
        @(negedge CLK);
        bus.START = 1'b1;
        bus.OP    = op;
        bus.A     = a;
        bus.B     = b;
        if (push) begin
            sbq.push_back(model(op, a, b));
            pushCount++;
        end
        @(posedge CLK);
        #1;
        bus.START = 1'b0;
        bus.OP    = 1'($urandom);
        bus.A     = N'($urandom);
        bus.B     = N'($urandom);
    endtask

    task automatic waitDone(output int cycles);
        bit found;
        found  = 1'b0;
        cycles = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge CLK);
            if (bus.DONE) begin
                found = 1'b1;
                break;
            end
            checkOutput("busy_run", bus.BUSY, 1);
            cycles++;
        end
        checkOutput("done_seen", found, 1);
        checkOutput("busy_done", bus.BUSY, 1);
    endtask

    task automatic checkAfterDone();
        @(negedge CLK);
        checkOutput("done_pulse", bus.DONE, 0);
        checkOutput("busy_idle", bus.BUSY, 0);
    endtask

    // Scoreboard consumer: every DONE must match the oldest pending expectation.
    always @(negedge CLK) begin
        if (N_RESET && bus.DONE) begin
            logic [2*N:0] exp;
            doneCount++;
            checkOutput("sb_pending", sbq.size() != 0, 1);
            if (sbq.size() != 0) begin
                exp = sbq.pop_front();
                checkOutput("y", bus.Y, exp[2*N:1]);
                checkOutput("dbz", bus.DBZ, exp[0]);
            end
        end
    end

    initial begin
        int cycles;
        int doneSnap;
        logic [2*N:0] ref_v;

        N_RESET   = 1'b0;
        bus.START = 1'b0;
        bus.OP    = 1'b0;
        bus.A     = '0;
        bus.B     = '0;
        #12;
        checkOutput("rst_busy", bus.BUSY, 0);
        checkOutput("rst_done", bus.DONE, 0);
        checkOutput("rst_y", bus.Y, 0);
        checkOutput("rst_dbz", bus.DBZ, 0);
        @(negedge CLK);
        N_RESET = 1'b1;

        $display("[TB] zero multiply and latency");
        applyStimulus(1'b0, 4'd0, 4'd0, 1);
        waitDone(cycles);
        checkOutput("latency_0x0", cycles, N + 1);
        checkAfterDone();

        $display("[TB] 15*15 and result hold");
        applyStimulus(1'b0, 4'd15, 4'd15, 1);
        waitDone(cycles);
        checkOutput("latency_15x15", cycles, N + 1);
        checkAfterDone();
        repeat (3) @(negedge CLK);
        ref_v = model(1'b0, 4'd15, 4'd15);
        checkOutput("y_hold", bus.Y, ref_v[2*N:1]);

        $display("[TB] divide 13/4 then 7/0");
        applyStimulus(1'b1, 4'd13, 4'd4, 1);
        waitDone(cycles);
        checkOutput("latency_div", cycles, N + 1);
        checkAfterDone();
        applyStimulus(1'b1, 4'd7, 4'd0, 1);
        waitDone(cycles);
        checkOutput("latency_dbz", cycles, N + 1);
        checkAfterDone();
        repeat (2) @(negedge CLK);
        ref_v = model(1'b1, 4'd7, 4'd0);
        checkOutput("dbz_hold", bus.DBZ, ref_v[0]);
        checkOutput("dbz_y_hold", bus.Y, ref_v[2*N:1]);

        $display("[TB] START during RUN ignored, then back-to-back");
        doneSnap = doneCount;
        applyStimulus(1'b0, 4'd3, 4'd5, 1);
        @(negedge CLK);
        @(negedge CLK);
        bus.START = 1'b1;
        bus.A     = 4'd9;
        bus.B     = 4'd9;
        @(posedge CLK);
        #1;
        bus.START = 1'b0;
        waitDone(cycles);
        applyStimulus(1'b0, 4'd11, 4'd13, 1);
        waitDone(cycles);
        checkOutput("latency_b2b", cycles, N + 1);
        checkAfterDone();
        repeat (N + 3) @(negedge CLK);
        checkOutput("single_done", doneCount - doneSnap, 2);

        $display("[TB] asynchronous reset mid-run");
        applyStimulus(1'b0, 4'd15, 4'd15, 0);
        doneSnap = doneCount;
        @(posedge CLK);
        @(posedge CLK);
        #2;
        N_RESET = 1'b0;
        #1;
        checkOutput("arst_busy", bus.BUSY, 0);
        checkOutput("arst_done", bus.DONE, 0);
        checkOutput("arst_y", bus.Y, 0);
        checkOutput("arst_dbz", bus.DBZ, 0);
        repeat (3) @(negedge CLK);
        N_RESET = 1'b1;
        repeat (N + 3) @(negedge CLK);
        checkOutput("arst_no_done", doneCount - doneSnap, 0);
        checkOutput("arst_busy_idle", bus.BUSY, 0);
        applyStimulus(1'b0, 4'd6, 4'd7, 1);
        waitDone(cycles);
        checkOutput("latency_6x7", cycles, N + 1);
        checkAfterDone();

        repeat (2) @(negedge CLK);
        checkOutput("done_total", doneCount, pushCount);
        checkOutput("sb_empty", sbq.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/muldiv_seq.md
Name: muldiv_seq

Overview:
- Multi-cycle unsigned multiply/divide sequencer. It replaces the wide combinational array multiplier wherever area matters more than latency.
- Operands are latched on a START handshake. One shift-add (multiply) or shift-subtract (restoring divide) step runs per clock for N clocks, then DONE pulses.
- Sits beside the combinational multiplier as a drop-in slow path; the full-width result format is identical.

Parameters:
- N, 4, operand width in bits (N >= 2); result width is 2*N.

Ports:
- CLK  input  1  rising-edge clock
- N_RESET  input  1  asynchronous active-low reset
- START  input  1  request; sampled only in IDLE
- OP  input  1  0 = multiply, 1 = divide
- A  input  N  multiplicand / dividend (unsigned)
- B  input  N  multiplier / divisor (unsigned)
- BUSY  output  1  high while an operation is in progress (RUN and DONE states)
- DONE  output  1  one-cycle pulse; Y valid from this cycle on
- Y  output  2*N  multiply: A*B; divide: {remainder, quotient}
- DBZ  output  1  divide-by-zero flag for the last completed operation

Behaviour:
- Clock and reset: one clock, CLK. N_RESET is asynchronous and active-low.
- Reset state: IDLE. Outputs: BUSY=0, DONE=0, Y=0, DBZ=0. Internal registers cleared, counter=0.
- States: IDLE, RUN, DONE.
- IDLE:
  - START=1 at a rising edge latches A, B and OP, sets counter=N and moves to RUN.
  - START=0 stays in IDLE.
- RUN:
  - One iteration per clock; counter decrements each iteration.
  - After the Nth iteration (counter reaches 0), move to DONE.
- DONE:
  - Y and DBZ are registered on entry and DONE=1 for exactly this one cycle.
  - Next state is always IDLE.
- Latency: START sampled at edge k gives DONE=1 in the cycle after edge k+N+1. Fixed; independent of operand values.
- Throughput: back-to-back operations are possible. START high in the IDLE cycle right after DONE is accepted.
- START while BUSY=1 (RUN or DONE): ignored; no queuing. The in-flight operation is unaffected.
- A, B, OP may change freely after the accepting edge.
- Y and DBZ hold their values until the next DONE or reset.
- Multiply: 2N-bit accumulator plus shifted multiplicand. Each step adds the multiplicand if the current multiplier LSB is 1, then shifts. Result is exact; max 15*15=225 for N=4, with no overflow possible.
- Divide: restoring algorithm with an N+1 bit partial remainder.
  - Each step: shift in the next dividend bit, trial-subtract B.
  - Quotient bit is 1 if the result is non-negative, and the remainder is kept; otherwise the remainder is restored.
  - Y[2N-1:N] = remainder, Y[N-1:0] = quotient.
- Divide by zero (B=0 at accept):
  - No special path; the algorithm naturally yields quotient = all ones and remainder = A.
  - DBZ=1 in the DONE cycle and held with Y.
  - Latency is unchanged.
- Multiply always sets DBZ=0.
- Reset mid-operation: immediate return to IDLE with all outputs zero. The partial result is discarded and no DONE is emitted.
- Counter width: $clog2(N+1) bits.

Optional Feature:
- Macro: MULDIV_DIV_EN.
- Defined: OP selects multiply or divide as above, and DBZ is active.
- Not defined:
  - Divide datapath is not compiled.
  - OP is ignored and every operation is a multiply.
  - DBZ is tied to 0.
  - Timing is identical.

Test Plan:
- Reset, then START with OP=0, A=0, B=0 -> DONE exactly N+1 cycles after the accepting edge; Y=0, DBZ=0, BUSY high through RUN and DONE.
- OP=0, A=15, B=15 (N=4) -> Y=225 (8'b11100001); DONE is a single-cycle pulse; Y holds until the next operation.
- OP=1, A=13, B=4 -> Y={4'd1, 4'd3}, DBZ=0. Then OP=1, A=7, B=0 -> Y={4'd7, 4'd15}, DBZ=1.
- Start OP=0, A=3, B=5; pulse START with A=9, B=9 at cycle 2 of RUN -> result 15, and only one DONE. Also issue START in the cycle right after DONE -> accepted.
- Start A=15, B=15; drop N_RESET mid-RUN asynchronously, between edges -> BUSY, DONE, Y, DBZ go to 0 immediately with no DONE. After release, 6*7 -> Y=42.
- Build without MULDIV_DIV_EN: OP=1, A=13, B=4 -> Y=52, DBZ=0.
